bus_protocol_target: RTL

Target (receiver) end of the dValid/dAck/data byte-transfer bus. Detects each transfer, returns dAck at a programmable point within the legal 2-4 clock window, and captures the byte into a small FIFO drained by a downstream valid/ready consumer. Also flags master-side protocol violations: early drop, late release and unstable data.

---
 rtl/bus_protocol_target.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bus_protocol_target.sv
// Target end of the dValid/dAck byte-transfer bus: acknowledges each transfer at a
// programmable offset, queues the byte in a small FIFO and flags master protocol errors.
module bus_protocol_target #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dValid,
  input  logic [7:0]       data,
  output logic             dAck,
  input  logic [1:0]       ack_dly,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             overflow,
  output logic             err_early,
  output logic             err_hold,
  output logic             err_unstable,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} state_t;

  state_t          state_r;
  logic [2:0]      n_r;
  logic [2:0]      k_r;
  logic [7:0]      ref_r;
  logic            chk_r;
  logic [7:0]      mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            full_s;
  logic            pop_s;
  logic            push_s;
  logic            ack_go_s;
  logic [2:0]      n_s;

  assign full_s   = (count_r == FULL_C);
  assign rd_valid = (count_r != {(AW+1){1'b0}});
  assign pop_s    = rd_valid && rd_ready;
  // A full FIFO still accepts the byte when the consumer pops on the same edge.
  assign push_s   = (state_r == ACK) && dValid && (!full_s || pop_s);
  assign rd_data  = rd_valid ? mem_r[rd_ptr_r] : 8'h00;
  assign n_s      = (ack_dly == 2'd0) ? 3'd2 : ({1'b0, ack_dly} + 3'd1);
  // Ack is deferred while full, but never past the last legal cycle.
  assign ack_go_s = ((k_r >= (n_r - 3'd1)) && !full_s) || (k_r == 3'd3);

  // Transfer FSM, error pulses and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= DONE;
      n_r          <= 3'd0;
      k_r          <= 3'd0;
      ref_r        <= 8'h00;
      chk_r        <= 1'b0;
      dAck         <= 1'b0;
      overflow     <= 1'b0;
      err_early    <= 1'b0;
      err_hold     <= 1'b0;
      err_unstable <= 1'b0;
      drop_cnt     <= {CNT_W{1'b0}};
    end else begin
      dAck         <= 1'b0;
      overflow     <= 1'b0;
      err_early    <= 1'b0;
      err_hold     <= 1'b0;
      err_unstable <= 1'b0;
      case (state_r)
        IDLE: begin
          if (dValid) begin
            n_r     <= n_s;
            ref_r   <= data;
            k_r     <= 3'd1;
            state_r <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (!dValid) begin
            err_early <= 1'b1;
            state_r   <= IDLE;
          end else begin
            if (data != ref_r) begin
              err_unstable <= 1'b1;
            end else begin
              err_unstable <= 1'b0;
            end
            if (ack_go_s) begin
              dAck    <= 1'b1;
              state_r <= ACK;
            end else begin
              k_r <= k_r + 3'd1;
            end
          end
        end
        ACK: begin
          if (!dValid) begin
            err_early <= 1'b1;
          end else if (!push_s) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
              drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              drop_cnt <= drop_cnt;
            end
          end else begin
            overflow <= 1'b0;
          end
          chk_r   <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          // Only the first edge after an ack checks for a late release.
          chk_r <= 1'b0;
          if (chk_r && dValid) begin
            err_hold <= 1'b1;
          end else begin
            err_hold <= 1'b0;
          end
          if (!dValid) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= DONE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

endmodule
